rv32v_pipeline_ctrl: RTL and testbench

Hazard and sequencing controller for the five-stage RV32V vector pipeline (fetch1, fetch2, decode, execute, memory). It collects per-stage busy flags, CSR-update and memory-stage exception events, and drives every stage's stall and flush. After a CSR write or an exception it runs a redirect/refill sequence. It also keeps two performance counters for stall cycles and flush events.

---
 rtl/rv32v_pipeline_ctrl.sv | 129 ++++++++++++
 tb/tb_rv32v_pipeline_ctrl.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/rv32v_pipeline_ctrl.sv
// rv32v_pipeline_ctrl
// Hazard and sequencing controller for the five-stage vector pipeline
// (f1, f2, dec, ex, mem). Stalls and flushes are combinational from the
// busy/event inputs and the RUN/HOLD state. A CSR retire or a memory-stage
// exception flushes the younger stages and starts a fetch refill hold.
//
// Ports:
//   CLK, nRST                     clock (rising), async active-low reset
//   busy_f1..busy_mem             stage cannot advance this cycle
//   csr_update                    mem stage retiring a vtype/vl/vstart write
//   exception_mem                 mem stage exception
//   stall_f1..stall_mem           hold that stage's pipeline register
//   flush_f1..flush_mem           invalidate what that stage latches next edge
//   hold_active                   controller is in HOLD
//   stall_cycles                  saturating count of busy-induced fetch stalls
//   flush_events                  wrapping count of EXC/CSR events
module rv32v_pipeline_ctrl #(
  parameter int REFILL_CYCLES = 2,
  parameter int STALL_CNT_W   = 32,
  parameter int FLUSH_CNT_W   = 16
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic                   busy_f1,
  input  logic                   busy_f2,
  input  logic                   busy_dec,
  input  logic                   busy_ex,
  input  logic                   busy_mem,
  input  logic                   csr_update,
  input  logic                   exception_mem,
  output logic                   stall_f1,
  output logic                   stall_f2,
  output logic                   stall_dec,
  output logic                   stall_ex,
  output logic                   stall_mem,
  output logic                   flush_f1,
  output logic                   flush_f2,
  output logic                   flush_dec,
  output logic                   flush_ex,
  output logic                   flush_mem,
  output logic                   hold_active,
  output logic [STALL_CNT_W-1:0] stall_cycles,
  output logic [FLUSH_CNT_W-1:0] flush_events
);

  localparam int HW = (REFILL_CYCLES > 0) ? $clog2(REFILL_CYCLES + 1) : 1;

  typedef enum logic {RUN = 1'b0, HOLD = 1'b1} state_t;

  state_t          state, state_n;
  logic [HW-1:0]   hold_cnt, hold_cnt_n;

  // Stage vectors are indexed 0=f1 .. 4=mem (program order, oldest at 4).
  logic [4:0] busy, bp, stall_bp, flush_bp, stall, flush;
  logic       evt_exc, evt_csr, evt, sc_inc;

  assign busy    = {busy_mem, busy_ex, busy_dec, busy_f2, busy_f1};
  assign evt_exc = exception_mem;
  assign evt_csr = csr_update & ~busy_mem & ~exception_mem;
  assign evt     = evt_exc | evt_csr;

  always_comb begin
    // In HOLD fetch is already frozen, so only dec/ex/mem back-pressure matters.
    bp = (state == HOLD) ? {busy[4:2], 2'b00} : busy;

    // stall_bp[i]: some stage at i or further along the pipe is busy.
    stall_bp    = '0;
    stall_bp[4] = bp[4];
    for (int i = 3; i >= 0; i--) stall_bp[i] = stall_bp[i+1] | bp[i];

    // Bubble goes into the first un-stalled stage behind the oldest busy one.
    flush_bp    = '0;
    for (int i = 1; i < 5; i++) flush_bp[i] = stall_bp[i-1] & ~stall_bp[i];

    stall = '0;
    flush = '0;
    if (!nRST) begin
      flush = 5'b11111;
    end else if (evt_exc) begin
      flush = 5'b11111;
    end else if (evt_csr) begin
      flush = 5'b01111;               // CSR instruction in mem retires
    end else if (state == HOLD) begin
      stall = stall_bp | 5'b00011;
      flush = (flush_bp | 5'b00100) & ~stall;
    end else begin
      stall = stall_bp;
      flush = flush_bp;
    end
  end

  assign {stall_mem, stall_ex, stall_dec, stall_f2, stall_f1} = stall;
  assign {flush_mem, flush_ex, flush_dec, flush_f2, flush_f1} = flush;
  assign hold_active = (state == HOLD);

  always_comb begin
    state_n    = state;
    hold_cnt_n = hold_cnt;
    if (evt) begin
      if (REFILL_CYCLES > 0) begin
        state_n    = HOLD;
        hold_cnt_n = HW'(REFILL_CYCLES);
      end
    end else if (state == HOLD) begin
      hold_cnt_n = hold_cnt - HW'(1);
      if (hold_cnt == HW'(1)) state_n = RUN;
    end
  end

  // Only back-pressure fetch stalls in RUN count; hold and event cycles do not.
  assign sc_inc = (state == RUN) & ~evt & stall_bp[0];

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state        <= RUN;
      hold_cnt     <= '0;
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      state    <= state_n;
      hold_cnt <= hold_cnt_n;
      if (sc_inc && (stall_cycles != '1))
        stall_cycles <= stall_cycles + STALL_CNT_W'(1);
      if (evt)
        flush_events <= flush_events + FLUSH_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_rv32v_pipeline_ctrl.sv
// Scoreboard bench for rv32v_pipeline_ctrl: stimulus pushes the hand-derived
// expected outputs of each cycle; the monitor pops and compares at negedge.
// Vector bit order everywhere: {mem, ex, dec, f2, f1}.
module tb_rv32v_pipeline_ctrl;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        busy_f1, busy_f2, busy_dec, busy_ex, busy_mem;
  logic        csr_update, exception_mem;
  logic        stall_f1, stall_f2, stall_dec, stall_ex, stall_mem;
  logic        flush_f1, flush_f2, flush_dec, flush_ex, flush_mem;
  logic        hold_active;
  logic [31:0] stall_cycles;
  logic [15:0] flush_events;

  always #5 CLK = ~CLK;

  rv32v_pipeline_ctrl #(.REFILL_CYCLES(2), .STALL_CNT_W(32), .FLUSH_CNT_W(16)) dut (
    .CLK(CLK), .nRST(nRST),
    .busy_f1(busy_f1), .busy_f2(busy_f2), .busy_dec(busy_dec),
    .busy_ex(busy_ex), .busy_mem(busy_mem),
    .csr_update(csr_update), .exception_mem(exception_mem),
    .stall_f1(stall_f1), .stall_f2(stall_f2), .stall_dec(stall_dec),
    .stall_ex(stall_ex), .stall_mem(stall_mem),
    .flush_f1(flush_f1), .flush_f2(flush_f2), .flush_dec(flush_dec),
    .flush_ex(flush_ex), .flush_mem(flush_mem),
    .hold_active(hold_active), .stall_cycles(stall_cycles),
    .flush_events(flush_events)
  );

  typedef struct packed {
    logic [4:0]  stall;
    logic [4:0]  flush;
    logic        hold;
    logic [31:0] sc;
    logic [15:0] fe;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   step_no  = 0;

  // One cycle of stimulus with its expected response.
  task automatic step(input logic rst_n, input logic [4:0] b, input logic csr,
                      input logic exc, input logic [4:0] es, input logic [4:0] ef,
                      input logic eh, input int sc, input int fe);
    exp_t e;
    @(posedge CLK);
    #1;
    nRST = rst_n;
    {busy_mem, busy_ex, busy_dec, busy_f2, busy_f1} = b;
    csr_update    = csr;
    exception_mem = exc;
    e.stall = es; e.flush = ef; e.hold = eh;
    e.sc = 32'(sc); e.fe = 16'(fe);
    exp_q.push_back(e);
  endtask

  // Monitor: every cycle with a pending expectation is compared.
  initial begin
    exp_t e;
    logic [4:0] as, af;
    forever begin
      @(negedge CLK);
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        as = {stall_mem, stall_ex, stall_dec, stall_f2, stall_f1};
        af = {flush_mem, flush_ex, flush_dec, flush_f2, flush_f1};
        step_no++;
        checks++;
        if (as !== e.stall || af !== e.flush || hold_active !== e.hold ||
            stall_cycles !== e.sc || flush_events !== e.fe) begin
          failures++;
          $display("FAIL step%0d: got stall=%b flush=%b hold=%b sc=%0d fe=%0d, want stall=%b flush=%b hold=%b sc=%0d fe=%0d",
                   step_no, as, af, hold_active, stall_cycles, flush_events,
                   e.stall, e.flush, e.hold, e.sc, e.fe);
        end
      end
    end
  end

  initial begin
    nRST = 1'b0;
    {busy_mem, busy_ex, busy_dec, busy_f2, busy_f1} = '0;
    csr_update = 1'b0; exception_mem = 1'b0;

    //     rst busy      csr exc stall     flush     hold sc fe
    // reset: all flushes regardless of inputs, counters clear
    step(0, 5'b01000, 0, 0, 5'b00000, 5'b11111, 0, 0, 0);
    step(0, 5'b00000, 1, 1, 5'b00000, 5'b11111, 0, 0, 0);
    // idle
    step(1, 5'b00000, 0, 0, 5'b00000, 5'b00000, 0, 0, 0);
    // busy_ex for 3 cycles
    step(1, 5'b01000, 0, 0, 5'b01111, 5'b10000, 0, 0, 0);
    step(1, 5'b01000, 0, 0, 5'b01111, 5'b10000, 0, 1, 0);
    step(1, 5'b01000, 0, 0, 5'b01111, 5'b10000, 0, 2, 0);
    step(1, 5'b00000, 0, 0, 5'b00000, 5'b00000, 0, 3, 0);
    // CSR event at t, hold t+1..t+2, RUN at t+3
    step(1, 5'b00000, 1, 0, 5'b00000, 5'b01111, 0, 3, 0);
    step(1, 5'b00000, 0, 0, 5'b00011, 5'b00100, 1, 3, 1);
    step(1, 5'b00000, 0, 0, 5'b00011, 5'b00100, 1, 3, 1);
    step(1, 5'b00000, 0, 0, 5'b00000, 5'b00000, 0, 3, 1);
    // CSR blocked by busy_mem for 2 cycles, fires on the 3rd
    step(1, 5'b10000, 1, 0, 5'b11111, 5'b00000, 0, 3, 1);
    step(1, 5'b10000, 1, 0, 5'b11111, 5'b00000, 0, 4, 1);
    step(1, 5'b00000, 1, 0, 5'b00000, 5'b01111, 0, 5, 1);
    // exception at t+1 of that hold restarts it
    step(1, 5'b00000, 0, 1, 5'b00000, 5'b11111, 1, 5, 2);
    step(1, 5'b00000, 0, 0, 5'b00011, 5'b00100, 1, 5, 3);
    step(1, 5'b00000, 0, 0, 5'b00011, 5'b00100, 1, 5, 3);
    step(1, 5'b00000, 0, 0, 5'b00000, 5'b00000, 0, 5, 3);
    // back-pressure during HOLD: stall_dec overrides flush_dec; f1 busy ignored
    step(1, 5'b00000, 1, 0, 5'b00000, 5'b01111, 0, 5, 3);
    step(1, 5'b01000, 0, 0, 5'b01111, 5'b10000, 1, 5, 4);
    step(1, 5'b00001, 0, 0, 5'b00011, 5'b00100, 1, 5, 4);
    step(1, 5'b00000, 0, 0, 5'b00000, 5'b00000, 0, 5, 4);
    // priority resolution in RUN
    step(1, 5'b10100, 0, 0, 5'b11111, 5'b00000, 0, 5, 4);
    step(1, 5'b00001, 0, 0, 5'b00001, 5'b00010, 0, 6, 4);
    step(1, 5'b00011, 0, 0, 5'b00011, 5'b00100, 0, 7, 4);
    step(1, 5'b00100, 0, 0, 5'b00111, 5'b01000, 0, 8, 4);
    // event beats back-pressure
    step(1, 5'b01000, 1, 0, 5'b00000, 5'b01111, 0, 9, 4);
    // reset mid-HOLD, then no residual hold
    step(0, 5'b00000, 0, 0, 5'b00000, 5'b11111, 0, 0, 0);
    step(1, 5'b00000, 0, 0, 5'b00000, 5'b00000, 0, 0, 0);
    step(1, 5'b10000, 0, 0, 5'b11111, 5'b00000, 0, 0, 0);
    step(1, 5'b00000, 0, 0, 5'b00000, 5'b00000, 0, 1, 0);

    begin
      int guard = 0;
      while (exp_q.size() > 0 && guard < 20) begin
        @(posedge CLK);
        guard++;
      end
      if (exp_q.size() > 0) begin
        checks++;
        failures++;
        $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
      end
    end
    @(posedge CLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
